// File: rtl/setn_pulse_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// setn_pulse_sequencer_pkg
//   Shared types and constants for the SETN pulse sequencer and its
//   cycle down-counter.
//   Contents:
//     state_t     - sequencer state (IDLE / ASSERT / RELEASE), IDLE = 0
//     CNT_W       - width of the shared cycle counter
//     PULSE_MAX   - largest legal SETN low width, in clock cycles
//     RECOV_MAX   - largest legal recovery margin, in clock cycles
//     cyc_to_cnt  - converts a cycle count into the counter reload value
// -----------------------------------------------------------------------------
package setn_pulse_sequencer_pkg;

   localparam int CNT_W     = 4;
   localparam int PULSE_MAX = 15;
   localparam int RECOV_MAX = 15;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      RELEASE = 2'd2
   } state_t;

   // A phase of N cycles reloads the counter with N-1: the phase ends on the
   // edge that sees the counter at zero.
   function automatic logic [CNT_W-1:0] cyc_to_cnt(input int cyc);
      return CNT_W'(cyc - 1);
   endfunction

endpackage

// File: rtl/setn_pulse_sequencer_cyc_down_counter.sv
// -----------------------------------------------------------------------------
// setn_pulse_sequencer_cyc_down_counter
//   Reloadable, non-wrapping cycle down-counter shared by the ASSERT and
//   RELEASE phases of the sequencer.
//   Ports:
//     i_clk      - clock, rising edge
//     i_rst      - synchronous reset, active high (counter -> 0)
//     i_load     - load i_load_val on the next edge (wins over i_dec)
//     i_load_val - reload value
//     i_dec      - decrement on the next edge; holds at zero
//     o_zero     - counter currently equals zero
// -----------------------------------------------------------------------------
module setn_pulse_sequencer_cyc_down_counter
   import setn_pulse_sequencer_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   // NOTE: clocked state uses non-blocking (<=) so every flop samples the
   // values from before the edge, independent of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/setn_pulse_sequencer.sv
// -----------------------------------------------------------------------------
// setn_pulse_sequencer
//   Synchronous initiator for the active-low asynchronous-set pin of a bank
//   of set-type flops. On request it drives a SETN low pulse of PULSE_CYC
//   cycles, holds the bank clock enable low for a further RECOV_CYC cycles,
//   then signals completion. The bank's Q outputs are checked at the end of
//   the pulse; a bank that did not reach all-ones raises a sticky error.
//   Parameters:
//     WIDTH     - flops in the driven bank (>= 1)
//     PULSE_CYC - SETN low width in cycles (1..15)
//     RECOV_CYC - cycles from SETN release to clock enable return (1..15)
//   Ports:
//     i_clk     - clock, rising edge
//     i_rst     - synchronous reset, active high; aborts any sequence
//     i_req     - set request, level-sampled, accepted only in IDLE
//     i_err_clr - clears the sticky error on the next edge
//     i_q_fb    - Q outputs of the driven bank
//     o_setn    - active-low set to the bank (registered)
//     o_clk_en  - bank clock enable, low during a sequence (registered)
//     o_busy    - sequence in progress (registered)
//     o_done    - one-cycle completion pulse (registered)
//     o_err     - sticky: bank was not all-ones at the end of the pulse
// -----------------------------------------------------------------------------
module setn_pulse_sequencer
   import setn_pulse_sequencer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int PULSE_CYC = 2,
   parameter int RECOV_CYC = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req,
   input  logic             i_err_clr,
   input  logic [WIDTH-1:0] i_q_fb,
   output logic             o_setn,
   output logic             o_clk_en,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err
);

   // ---------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ---------------------------------------------------------------------
   if (WIDTH < 1) begin : g_bad_width
      $error("setn_pulse_sequencer: WIDTH must be >= 1");
   end
   if ((PULSE_CYC < 1) || (PULSE_CYC > PULSE_MAX)) begin : g_bad_pulse
      $error("setn_pulse_sequencer: PULSE_CYC must be in 1..%0d", PULSE_MAX);
   end
   if ((RECOV_CYC < 1) || (RECOV_CYC > RECOV_MAX)) begin : g_bad_recov
      $error("setn_pulse_sequencer: RECOV_CYC must be in 1..%0d", RECOV_MAX);
   end

   localparam logic [CNT_W-1:0] PULSE_LOAD = cyc_to_cnt(PULSE_CYC);
   localparam logic [CNT_W-1:0] RECOV_LOAD = cyc_to_cnt(RECOV_CYC);

   // ---------------------------------------------------------------------
   // Declarations
   // ---------------------------------------------------------------------
   state_t           r_state;
   state_t           w_state_nxt;

   logic             w_cnt_load;
   logic [CNT_W-1:0] w_cnt_load_val;
   logic             w_cnt_dec;
   logic             w_cnt_zero;

   logic             w_setn_d;
   logic             w_clk_en_d;
   logic             w_busy_d;
   logic             w_done_d;
   logic             w_err_set;

   logic             r_setn;
   logic             r_clk_en;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

   // ---------------------------------------------------------------------
   // Shared phase counter
   // ---------------------------------------------------------------------
   setn_pulse_sequencer_cyc_down_counter u_cyc_down_counter (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_load_val),
      .i_dec      (w_cnt_dec),
      .o_zero     (w_cnt_zero)
   );

   // ---------------------------------------------------------------------
   // FSM: state register (outputs are registered alongside the state so
   // SETN and friends come straight from flops and cannot glitch)
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_setn   <= 1'b1;
         r_clk_en <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_setn   <= w_setn_d;
         r_clk_en <= w_clk_en_d;
         r_busy   <= w_busy_d;
         r_done   <= w_done_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state and counter control
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the case can leave it unassigned and infer a latch.
      w_state_nxt    = r_state;
      w_cnt_load     = 1'b0;
      w_cnt_load_val = PULSE_LOAD;
      w_cnt_dec      = 1'b0;

      case (r_state)
         IDLE: begin
            if (i_req) begin
               w_state_nxt    = ASSERT;
               w_cnt_load     = 1'b1;
               w_cnt_load_val = PULSE_LOAD;
            end
         end
         ASSERT: begin
            w_cnt_dec = 1'b1;
            if (w_cnt_zero) begin
               w_state_nxt    = RELEASE;
               w_cnt_load     = 1'b1;
               w_cnt_load_val = RECOV_LOAD;
            end
         end
         RELEASE: begin
            w_cnt_dec = 1'b1;
            if (w_cnt_zero) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: output decode. Values are computed from the state being entered
   // so the registered outputs change on the same edge as the state.
   // ---------------------------------------------------------------------
   always_comb begin
      w_setn_d   = (w_state_nxt != ASSERT);
      w_clk_en_d = (w_state_nxt == IDLE);
      w_busy_d   = (w_state_nxt != IDLE);
      w_done_d   = (r_state == RELEASE) && (w_state_nxt == IDLE);
   end

   // ---------------------------------------------------------------------
   // Sticky error: the bank is checked on the last edge of the pulse.
   // A detection on the same edge as a clear wins.
   // ---------------------------------------------------------------------
   assign w_err_set = (r_state == ASSERT) && w_cnt_zero && (i_q_fb != '1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_err <= 1'b0;
      end else if (w_err_set) begin
         r_err <= 1'b1;
      end else if (i_err_clr) begin
         r_err <= 1'b0;
      end
   end

   assign o_setn   = r_setn;
   assign o_clk_en = r_clk_en;
   assign o_busy   = r_busy;
   assign o_done   = r_done;
   assign o_err    = r_err;

endmodule

// File: tb/tb_setn_pulse_sequencer.sv
// -----------------------------------------------------------------------------
// tb_setn_pulse_sequencer
//   Directed bench for setn_pulse_sequencer. dut_a uses the default timing
//   (2-cycle pulse, 1-cycle recovery); dut_b uses a 1-cycle pulse and 3-cycle
//   recovery. Both share the stimulus; each is only checked in its own tests.
//   Outputs are compared as {setn, clk_en, busy, done, err}, 1 ns after the
//   edge whose effect is being checked.
// -----------------------------------------------------------------------------
module tb_setn_pulse_sequencer;

   localparam int W = 8;

   // Expected output patterns {setn, clk_en, busy, done, err}
   localparam logic [4:0] E_IDLE = 5'b11000;
   localparam logic [4:0] E_ASRT = 5'b00100;
   localparam logic [4:0] E_REL  = 5'b10100;
   localparam logic [4:0] E_DONE = 5'b11010;
   localparam logic [4:0] E_ERR  = 5'b00001;

   logic         clk = 1'b0;
   logic         rst;
   logic         req;
   logic         err_clr;
   logic [W-1:0] q_fb;

   logic a_setn, a_clk_en, a_busy, a_done, a_err;
   logic b_setn, b_clk_en, b_busy, b_done, b_err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string        name;
      logic         rst;
      logic         req;
      logic         err_clr;
      logic [W-1:0] q_fb;
      logic [4:0]   exp;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   setn_pulse_sequencer #(.WIDTH(W), .PULSE_CYC(2), .RECOV_CYC(1)) dut_a (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_req     (req),
      .i_err_clr (err_clr),
      .i_q_fb    (q_fb),
      .o_setn    (a_setn),
      .o_clk_en  (a_clk_en),
      .o_busy    (a_busy),
      .o_done    (a_done),
      .o_err     (a_err)
   );

   setn_pulse_sequencer #(.WIDTH(W), .PULSE_CYC(1), .RECOV_CYC(3)) dut_b (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_req     (req),
      .i_err_clr (err_clr),
      .i_q_fb    (q_fb),
      .o_setn    (b_setn),
      .o_clk_en  (b_clk_en),
      .o_busy    (b_busy),
      .o_done    (b_done),
      .o_err     (b_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input string name, input logic r, input logic q, input logic c,
                      input logic [W-1:0] f, input logic [4:0] e);
      vec_t v;
      v.name    = name;
      v.rst     = r;
      v.req     = q;
      v.err_clr = c;
      v.q_fb    = f;
      v.exp     = e;
      vecs.push_back(v);
   endtask

   initial begin
      int n_dones;
      logic [4:0] exp_v;

      rst     = 1'b1;
      req     = 1'b0;
      err_clr = 1'b0;
      q_fb    = 8'hFF;

      // ---- vector table: each row drives inputs, then checks after the edge
      //         name          rst   req   clr   q_fb   expected
      add("reset",           1'b1, 1'b0, 1'b0, 8'hFF, E_IDLE);
      // Passing sequence: REQ for one cycle at edge 0
      add("pass_e0",         1'b0, 1'b1, 1'b0, 8'hFF, E_ASRT);
      add("pass_e1",         1'b0, 1'b0, 1'b0, 8'hFF, E_ASRT);
      add("pass_e2",         1'b0, 1'b0, 1'b0, 8'hFF, E_REL);
      add("pass_e3",         1'b0, 1'b0, 1'b0, 8'hFF, E_DONE);
      add("pass_e4",         1'b0, 1'b0, 1'b0, 8'hFF, E_IDLE);
      // Failing readback (bit 0 stuck low), then clear
      add("fail_e0",         1'b0, 1'b1, 1'b0, 8'hFE, E_ASRT);
      add("fail_e1",         1'b0, 1'b0, 1'b0, 8'hFE, E_ASRT);
      add("fail_e2",         1'b0, 1'b0, 1'b0, 8'hFE, E_REL  | E_ERR);
      add("fail_e3",         1'b0, 1'b0, 1'b0, 8'hFF, E_DONE | E_ERR);
      add("fail_e4",         1'b0, 1'b0, 1'b0, 8'hFF, E_IDLE | E_ERR);
      add("fail_req_noclr",  1'b0, 1'b0, 1'b0, 8'hFF, E_IDLE | E_ERR);
      add("fail_clr",        1'b0, 1'b0, 1'b1, 8'hFF, E_IDLE);
      add("fail_after_clr",  1'b0, 1'b0, 1'b0, 8'hFF, E_IDLE);
      // Reset in the middle of ASSERT, then a full sequence
      add("abort_e0",        1'b0, 1'b1, 1'b0, 8'hFF, E_ASRT);
      add("abort_rst",       1'b1, 1'b0, 1'b0, 8'hFF, E_IDLE);
      add("abort_idle",      1'b0, 1'b0, 1'b0, 8'hFF, E_IDLE);
      add("abort_re_e0",     1'b0, 1'b1, 1'b0, 8'hFF, E_ASRT);
      add("abort_re_e1",     1'b0, 1'b0, 1'b0, 8'hFF, E_ASRT);
      add("abort_re_e2",     1'b0, 1'b0, 1'b0, 8'hFF, E_REL);
      add("abort_re_e3",     1'b0, 1'b0, 1'b0, 8'hFF, E_DONE);
      // Detection and clear on the same edge: set wins
      add("setwin_e0",       1'b0, 1'b1, 1'b0, 8'h00, E_ASRT);
      add("setwin_e1",       1'b0, 1'b0, 1'b0, 8'h00, E_ASRT);
      add("setwin_e2",       1'b0, 1'b0, 1'b1, 8'h00, E_REL  | E_ERR);
      add("setwin_e3",       1'b0, 1'b0, 1'b0, 8'hFF, E_DONE | E_ERR);
      add("setwin_clr",      1'b0, 1'b0, 1'b1, 8'hFF, E_IDLE);

      foreach (vecs[i]) begin
         rst     = vecs[i].rst;
         req     = vecs[i].req;
         err_clr = vecs[i].err_clr;
         q_fb    = vecs[i].q_fb;
         tick();
         check(vecs[i].name, {a_setn, a_clk_en, a_busy, a_done, a_err}, vecs[i].exp);
      end

      // ---- REQ held high: 2-cycle pulses every 4 cycles, DONE at 3, 7, 11
      rst     = 1'b0;
      err_clr = 1'b0;
      q_fb    = 8'hFF;
      req     = 1'b1;
      n_dones = 0;
      for (int e = 0; e < 12; e++) begin
         tick();
         case (e % 4)
            0, 1:    exp_v = E_ASRT;
            2:       exp_v = E_REL;
            default: exp_v = E_DONE;
         endcase
         check($sformatf("hold_e%0d", e), {a_setn, a_clk_en, a_busy, a_done, a_err}, exp_v);
         if (a_done) n_dones++;
      end
      req = 1'b0;
      check("hold_done_count", n_dones, 3);
      tick();
      check("hold_idle", {a_setn, a_clk_en, a_busy, a_done, a_err}, E_IDLE);

      // ---- dut_b: 1-cycle pulse, 3-cycle recovery, DONE at edge 4
      rst = 1'b1;
      tick();
      check("b_reset", {b_setn, b_clk_en, b_busy, b_done, b_err}, E_IDLE);
      rst = 1'b0;
      req = 1'b1;
      for (int e = 0; e < 6; e++) begin
         tick();
         req = 1'b0;
         exp_v[4] = (e != 0);
         exp_v[3] = (e >= 4);
         exp_v[2] = (e < 4);
         exp_v[1] = (e == 4);
         exp_v[0] = 1'b0;
         check($sformatf("b_e%0d", e), {b_setn, b_clk_en, b_busy, b_done, b_err}, exp_v);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
